// File: rtl/operand_fetch_stage.sv
// ID/EX boundary: resolves RAW hazards by forwarding from EX/MEM/WB, inserts a
// one-cycle bubble on load-use, and registers the resolved operands for EX.
module operand_fetch_stage #(
  parameter int unsigned W     = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     PA,
  input  logic [W-1:0]     PB,
  input  logic [W-1:0]     PD,
  input  logic [AW-1:0]    RA,
  input  logic [AW-1:0]    RB,
  input  logic [AW-1:0]    RD,
  input  logic             valid_in,
  input  logic             use_a,
  input  logic             use_b,
  input  logic             use_d,
  input  logic             we_in,
  input  logic             load_in,
  input  logic             flush,
  input  logic             ex_hold,
  input  logic [AW-1:0]    ex_rd,
  input  logic [AW-1:0]    mem_rd,
  input  logic [AW-1:0]    wb_rd,
  input  logic             ex_we,
  input  logic             mem_we,
  input  logic             wb_we,
  input  logic             ex_load,
  input  logic [W-1:0]     ex_res,
  input  logic [W-1:0]     mem_res,
  input  logic [W-1:0]     wb_res,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  output logic [W-1:0]     op_d,
  output logic [AW-1:0]    rd_out,
  output logic             we_out,
  output logic             load_out,
  output logic             valid_out,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [AW-1:0]    src_addr [3];
  logic [W-1:0]     src_data [3];
  logic [W-1:0]     res      [3];
  logic [2:0]       src_use;
  logic [2:0]       src_hit;
  logic             lu;

  logic [W-1:0]     op_a_q, op_b_q, op_d_q;
  logic [AW-1:0]    rd_q;
  logic             we_q, load_q, valid_q;
  logic [CNT_W-1:0] cnt_q;

  assign src_addr[0] = RA;
  assign src_addr[1] = RB;
  assign src_addr[2] = RD;
  assign src_data[0] = PA;
  assign src_data[1] = PB;
  assign src_data[2] = PD;
  assign src_use     = {use_d, use_b, use_a};

  // A loading EX instruction has no result yet, so it never forwards.
  always_comb begin
    src_hit = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      res[i] = src_data[i];
      if (src_addr[i] == '0) begin
        res[i] = '0;
      end else if (ex_we && ex_rd == src_addr[i] && !ex_load) begin
        res[i] = ex_res;
      end else if (mem_we && mem_rd == src_addr[i]) begin
        res[i] = mem_res;
      end else if (wb_we && wb_rd == src_addr[i]) begin
        res[i] = wb_res;
      end
      src_hit[i] = src_use[i] && (src_addr[i] == ex_rd);
    end
  end

  assign lu    = valid_in && ex_load && ex_we && (ex_rd != '0) && (|src_hit);
  assign stall = (lu || ex_hold) && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      op_d_q  <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (flush) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      op_d_q  <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (ex_hold) begin
      op_a_q  <= op_a_q;
    end else if (lu) begin
      // Bubble; rd_out keeps its value since the slot is invalid anyway.
      op_a_q  <= '0;
      op_b_q  <= '0;
      op_d_q  <= '0;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      valid_q <= 1'b0;
      if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end else begin
      op_a_q  <= res[0];
      op_b_q  <= res[1];
      op_d_q  <= res[2];
      rd_q    <= RD;
      we_q    <= we_in && valid_in;
      load_q  <= load_in && valid_in;
      valid_q <= valid_in;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_d      = op_d_q;
  assign rd_out    = rd_q;
  assign we_out    = we_q;
  assign load_out  = load_q;
  assign valid_out = valid_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model.
module tb_operand_fetch_stage;
  localparam int W = 32;
  localparam int AW = 5;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] PA, PB, PD, ex_res, mem_res, wb_res;
  logic [AW-1:0] RA, RB, RD, ex_rd, mem_rd, wb_rd;
  logic valid_in, use_a, use_b, use_d, we_in, load_in, flush, ex_hold;
  logic ex_we, mem_we, wb_we, ex_load;
  logic [W-1:0] op_a, op_b, op_d;
  logic [AW-1:0] rd_out;
  logic we_out, load_out, valid_out, stall;
  logic [CNT_W-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // model state
  logic [W-1:0] m_a, m_b, m_d;
  logic [AW-1:0] m_rd;
  logic m_we, m_ld, m_v;
  int m_cnt;

  always #5 clk = ~clk;

  operand_fetch_stage #(.W(W), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .PA(PA), .PB(PB), .PD(PD),
    .RA(RA), .RB(RB), .RD(RD), .valid_in(valid_in),
    .use_a(use_a), .use_b(use_b), .use_d(use_d), .we_in(we_in),
    .load_in(load_in), .flush(flush), .ex_hold(ex_hold),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we), .ex_load(ex_load),
    .ex_res(ex_res), .mem_res(mem_res), .wb_res(wb_res),
    .op_a(op_a), .op_b(op_b), .op_d(op_d), .rd_out(rd_out),
    .we_out(we_out), .load_out(load_out), .valid_out(valid_out),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] resolve(input logic [AW-1:0] r, input logic [W-1:0] p);
    if (r == 0) return '0;
    if (ex_we && ex_rd == r && !ex_load) return ex_res;
    if (mem_we && mem_rd == r) return mem_res;
    if (wb_we && wb_rd == r) return wb_res;
    return p;
  endfunction

  function automatic bit m_lu();
    bit hit;
    hit = (use_a && RA == ex_rd) || (use_b && RB == ex_rd) || (use_d && RD == ex_rd);
    return valid_in && ex_load && ex_we && ex_rd != 0 && hit;
  endfunction

  function automatic bit m_stall();
    return (m_lu() || ex_hold) && !flush;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_a = 0; m_b = 0; m_d = 0; m_rd = 0; m_we = 0; m_ld = 0; m_v = 0; m_cnt = 0;
    end else if (flush) begin
      m_a = 0; m_b = 0; m_d = 0; m_rd = 0; m_we = 0; m_ld = 0; m_v = 0;
    end else if (ex_hold) begin
      // nothing changes
    end else if (m_lu()) begin
      m_a = 0; m_b = 0; m_d = 0; m_we = 0; m_ld = 0; m_v = 0;
      m_cnt = (m_cnt == (1 << CNT_W) - 1) ? m_cnt : m_cnt + 1;
    end else begin
      m_a = resolve(RA, PA);
      m_b = resolve(RB, PB);
      m_d = resolve(RD, PD);
      m_rd = RD;
      m_we = we_in && valid_in;
      m_ld = load_in && valid_in;
      m_v = valid_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_op_a", op_a, m_a);
      chk("m_op_b", op_b, m_b);
      chk("m_op_d", op_d, m_d);
      chk("m_rd_out", rd_out, m_rd);
      chk("m_we_out", we_out, m_we);
      chk("m_load_out", load_out, m_ld);
      chk("m_valid_out", valid_out, m_v);
      chk("m_stall_cnt", stall_cnt, m_cnt);
      chk("m_stall", stall, m_stall());
    end
  end

  task automatic clr();
    reset = 0; PA = 0; PB = 0; PD = 0; RA = 0; RB = 0; RD = 0;
    valid_in = 0; use_a = 0; use_b = 0; use_d = 0; we_in = 0; load_in = 0;
    flush = 0; ex_hold = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_we = 0; mem_we = 0; wb_we = 0; ex_load = 0; ex_res = 0; mem_res = 0; wb_res = 0;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu();
    valid_in = 1; use_a = 1; RA = 16; ex_load = 1; ex_we = 1; ex_rd = 16;
  endtask

  initial begin
    clr();
    // 1: reset with a live instruction presented
    reset = 1; valid_in = 1; use_a = 1; RA = 5; PA = 32'h55; RD = 9; we_in = 1;
    edge1();
    chk_en = 1;
    chk("rst_valid", valid_out, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_rd", rd_out, 0);
    chk("rst_cnt", stall_cnt, 0);
    reset = 0;
    edge1();
    chk("post_rst_op_a", op_a, 32'h55);
    chk("post_rst_valid", valid_out, 1);
    chk("post_rst_we", we_out, 1);
    chk("post_rst_rd", rd_out, 9);

    // 2: forwarding priority
    clr(); valid_in = 1; use_a = 1; RA = 6; PA = 32'h11;
    ex_we = 1; ex_rd = 6; ex_res = 32'h22; mem_we = 1; mem_rd = 6; mem_res = 32'h33;
    wb_we = 1; wb_rd = 6; wb_res = 32'h44;
    edge1(); chk("fwd_ex", op_a, 32'h22);
    ex_we = 0;
    edge1(); chk("fwd_mem", op_a, 32'h33);
    mem_we = 0;
    edge1(); chk("fwd_wb", op_a, 32'h44);
    wb_we = 0;
    edge1(); chk("fwd_none", op_a, 32'h11);

    // 3: g0 ignores forwarding and file data
    clr(); valid_in = 1; use_b = 1; RB = 0; PB = 32'hDEAD; ex_we = 1; ex_rd = 0; ex_res = 32'hBEEF;
    #1 chk("g0_stall", stall, 0);
    edge1(); chk("g0_op_b", op_b, 0);

    // 4: load-use bubble then MEM forward
    clr(); set_lu(); PA = 32'h99;
    #1 chk("lu_stall", stall, 1);
    edge1();
    chk("lu_valid", valid_out, 0);
    chk("lu_cnt", stall_cnt, 1);
    ex_load = 0; ex_we = 0; ex_rd = 0; mem_we = 1; mem_rd = 16; mem_res = 32'h1234;
    #1 chk("lu2_stall", stall, 0);
    edge1();
    chk("lu2_op_a", op_a, 32'h1234);
    chk("lu2_valid", valid_out, 1);
    clr(); set_lu(); use_a = 0; PA = 32'h77;
    #1 chk("nouse_stall", stall, 0);
    edge1();
    chk("nouse_op_a", op_a, 32'h77);
    chk("nouse_valid", valid_out, 1);

    // 5: flush and hold against load-use
    use_a = 1; flush = 1;
    #1 chk("flush_stall", stall, 0);
    edge1();
    chk("flush_valid", valid_out, 0);
    chk("flush_cnt", stall_cnt, 1);
    clr(); valid_in = 1; use_a = 1; RA = 3; PA = 32'hABC; RD = 7; we_in = 1;
    edge1();
    clr(); set_lu(); ex_hold = 1;
    #1 chk("hold_stall", stall, 1);
    edge1();
    chk("hold_op_a", op_a, 32'hABC);
    chk("hold_rd", rd_out, 7);
    chk("hold_valid", valid_out, 1);
    chk("hold_cnt", stall_cnt, 1);

    // 6: saturation
    ex_hold = 0;
    for (int i = 0; i < 20; i++) begin
      edge1();
      if (i == 12) chk("sat_14", stall_cnt, 14);
      if (i == 13) chk("sat_15", stall_cnt, 15);
    end
    chk("sat_final", stall_cnt, 15);
    reset = 1;
    edge1();
    chk("sat_reset", stall_cnt, 0);
    reset = 0;

    // randomized traffic; small address space keeps hazards frequent
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      PA = $urandom; PB = $urandom; PD = $urandom;
      ex_res = $urandom; mem_res = $urandom; wb_res = $urandom;
      RA = AW'($urandom_range(0, 3)); RB = AW'($urandom_range(0, 3));
      RD = AW'($urandom_range(0, 3));
      ex_rd = AW'($urandom_range(0, 3)); mem_rd = AW'($urandom_range(0, 3));
      wb_rd = AW'($urandom_range(0, 3));
      valid_in = ($urandom_range(0, 9) < 8);
      use_a = $urandom_range(0, 1); use_b = $urandom_range(0, 1); use_d = $urandom_range(0, 1);
      we_in = $urandom_range(0, 1); load_in = $urandom_range(0, 1);
      flush = ($urandom_range(0, 9) == 0);
      ex_hold = ($urandom_range(0, 99) < 15);
      ex_we = $urandom_range(0, 1); mem_we = $urandom_range(0, 1); wb_we = $urandom_range(0, 1);
      ex_load = ($urandom_range(0, 9) < 3);
      edge1();
    end

    @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
